// File: rtl/bcd_counter_4digits_if.sv
// Command/status bundle between a controller and the 4-digit BCD counter.
// The master drives commands; the slave returns the count and its flags.
interface bcd_counter_4digits_if;
    logic        clear;
    logic        load;
    logic [15:0] load_val;
    logic        en;
    logic        up;
    logic [15:0] count;
    logic        wrap;
    logic        load_err;
    logic        is_zero;

    modport master (
        output clear, load, load_val, en, up,
        input  count, wrap, load_err, is_zero
    );

    modport slave (
        input  clear, load, load_val, en, up,
        output count, wrap, load_err, is_zero
    );
endinterface

// File: rtl/bcd_counter_4digits.sv
// 4-digit packed-BCD up/down counter with clear, validated load and wrap pulse.
// 1-cycle latency on every command; no backpressure, a command is accepted every cycle.

module bcd_digit_slice (
    input  logic [3:0] dig_i,
    input  logic       up_i,
    input  logic       cy_i,
    output logic [3:0] dig_o,
    output logic       cy_o
);
    // cy_i/cy_o carry in the up direction and borrow in the down direction
    always_comb begin
        dig_o = dig_i;
        cy_o  = 1'b0;
        if (cy_i) begin
            if (up_i) begin
                if (dig_i == 4'd9) begin
                    dig_o = 4'd0;
                    cy_o  = 1'b1;
                end else begin
                    dig_o = dig_i + 4'd1;
                end
            end else begin
                if (dig_i == 4'd0) begin
                    dig_o = 4'd9;
                    cy_o  = 1'b1;
                end else begin
                    dig_o = dig_i - 4'd1;
                end
            end
        end
    end
endmodule

module bcd_counter_4digits (
    input  logic                      clk,
    input  logic                      rst_n,
    bcd_counter_4digits_if.slave      bus
);
    logic [15:0] count_q, count_d;
    logic        wrap_q, wrap_d;
    logic        load_err_q, load_err_d;

    logic [4:0]  cy;
    logic [15:0] step_val;
    logic        load_ok;

    assign cy[0] = 1'b1;

    for (genvar g = 0; g < 4; g++) begin : g_dig
        bcd_digit_slice u_slice (
            .dig_i (count_q[4*g +: 4]),
            .up_i  (bus.up),
            .cy_i  (cy[g]),
            .dig_o (step_val[4*g +: 4]),
            .cy_o  (cy[g+1])
        );
    end

    assign load_ok = (bus.load_val[15:12] <= 4'd9) && (bus.load_val[11:8] <= 4'd9) &&
                     (bus.load_val[7:4]   <= 4'd9) && (bus.load_val[3:0]  <= 4'd9);

    // A rejected load still pre-empts the count step, so the count simply holds
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = load_err_q;
        if (bus.clear) begin
            count_d    = 16'h0000;
            load_err_d = 1'b0;
        end else if (bus.load) begin
            if (load_ok) begin
                count_d    = bus.load_val;
                load_err_d = 1'b0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
            count_d = step_val;
            wrap_d  = cy[4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= 16'h0000;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
    assign bus.is_zero  = (count_q == 16'h0000);
endmodule

// File: tb/tb_bcd_counter_4digits.sv
// Directed and randomized checks of bcd_counter_4digits against hand-computed values and an integer model.
module tb_bcd_counter_4digits;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    bcd_counter_4digits_if bus ();

    bcd_counter_4digits dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic c, input logic l, input logic [15:0] v,
                       input logic e, input logic u);
        bus.clear    = c;
        bus.load     = l;
        bus.load_val = v;
        bus.en       = e;
        bus.up       = u;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic all_bcd(input logic [15:0] x);
        return (x[15:12] < 4'd10) && (x[11:8] < 4'd10) && (x[7:4] < 4'd10) && (x[3:0] < 4'd10);
    endfunction

    int          m;
    logic        merr;
    logic        mwrap;
    logic        c, l, e, u;
    int          dg [4];
    logic        vld;
    logic [15:0] v;

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        #12;
        chk("rst_count",    bus.count, 16'h0000);
        chk("rst_wrap",     16'(bus.wrap), 16'h0);
        chk("rst_load_err", 16'(bus.load_err), 16'h0);
        chk("rst_is_zero",  16'(bus.is_zero), 16'h1);
        rst_n = 1'b1;

        // Async reset mid-count
        drv(1'b0, 1'b1, 16'h0457, 1'b0, 1'b1); tick();
        chk("ld_0457", bus.count, 16'h0457);
        drv(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); tick();
        chk("step_0458", bus.count, 16'h0458);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count",    bus.count, 16'h0000);
        chk("arst_wrap",     16'(bus.wrap), 16'h0);
        chk("arst_load_err", 16'(bus.load_err), 16'h0);
        chk("arst_is_zero",  16'(bus.is_zero), 16'h1);
        #1 rst_n = 1'b1;
        tick();
        chk("resume_0001", bus.count, 16'h0001);

        // Carry ripple up and wrap
        drv(1'b0, 1'b1, 16'h0999, 1'b0, 1'b1); tick();
        drv(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); tick();
        chk("carry_1000", bus.count, 16'h1000);
        drv(1'b0, 1'b1, 16'h9998, 1'b0, 1'b1); tick();
        drv(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); tick();
        chk("up_9999",      bus.count, 16'h9999);
        chk("up_9999_wrap", 16'(bus.wrap), 16'h0);
        tick();
        chk("up_wrap_cnt",  bus.count, 16'h0000);
        chk("up_wrap",      16'(bus.wrap), 16'h1);
        drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1); tick();
        chk("up_wrap_end",  16'(bus.wrap), 16'h0);
        chk("idle_hold",    bus.count, 16'h0000);

        // Borrow ripple down and wrap
        drv(1'b0, 1'b1, 16'h1000, 1'b0, 1'b0); tick();
        drv(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); tick();
        chk("borrow_0999", bus.count, 16'h0999);
        drv(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0); tick();
        drv(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); tick();
        chk("dn_0000",      bus.count, 16'h0000);
        chk("dn_is_zero",   16'(bus.is_zero), 16'h1);
        chk("dn_0000_wrap", 16'(bus.wrap), 16'h0);
        tick();
        chk("dn_wrap_cnt",  bus.count, 16'h9999);
        chk("dn_wrap",      16'(bus.wrap), 16'h1);
        chk("dn_not_zero",  16'(bus.is_zero), 16'h0);

        // Invalid load is rejected and sticky
        drv(1'b0, 1'b1, 16'h0123, 1'b0, 1'b1); tick();
        drv(1'b0, 1'b1, 16'h12A4, 1'b0, 1'b1); tick();
        chk("bad_ld_hold", bus.count, 16'h0123);
        chk("bad_ld_err",  16'(bus.load_err), 16'h1);
        drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1); tick();
        chk("err_sticky",  16'(bus.load_err), 16'h1);
        drv(1'b0, 1'b1, 16'h0042, 1'b0, 1'b1); tick();
        chk("good_ld",     bus.count, 16'h0042);
        chk("good_ld_err", 16'(bus.load_err), 16'h0);

        // Priority
        drv(1'b0, 1'b1, 16'h0500, 1'b0, 1'b1); tick();
        drv(1'b0, 1'b1, 16'h0777, 1'b1, 1'b1); tick();
        chk("ld_over_en", bus.count, 16'h0777);
        drv(1'b0, 1'b1, 16'hF000, 1'b1, 1'b1); tick();
        chk("bad_ld_over_en",     bus.count, 16'h0777);
        chk("bad_ld_over_en_err", 16'(bus.load_err), 16'h1);
        drv(1'b1, 1'b1, 16'h0777, 1'b1, 1'b1); tick();
        chk("clr_wins",     bus.count, 16'h0000);
        chk("clr_wins_err", 16'(bus.load_err), 16'h0);

        // Randomized sweep against an integer model modulo 10000
        m    = 0;
        merr = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            c = ($urandom_range(0, 63) == 0);
            l = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) dg[k] = $urandom_range(0, 10);
            vld = (dg[0] < 10) && (dg[1] < 10) && (dg[2] < 10) && (dg[3] < 10);
            v   = {4'(dg[3]), 4'(dg[2]), 4'(dg[1]), 4'(dg[0])};
            drv(c, l, v, e, u);
            tick();
            mwrap = 1'b0;
            if (c) begin
                m    = 0;
                merr = 1'b0;
            end else if (l) begin
                if (vld) begin
                    m    = dg[3] * 1000 + dg[2] * 100 + dg[1] * 10 + dg[0];
                    merr = 1'b0;
                end else begin
                    merr = 1'b1;
                end
            end else if (e) begin
                if (u) begin
                    if (m == 9999) mwrap = 1'b1;
                    m = (m + 1) % 10000;
                end else begin
                    if (m == 0) mwrap = 1'b1;
                    m = (m + 9999) % 10000;
                end
            end
            chk("sweep_count", bus.count, to_bcd(m));
            chk("sweep_wrap",  16'(bus.wrap), 16'(mwrap));
            chk("sweep_err",   16'(bus.load_err), 16'(merr));
            chk("sweep_bcd",   16'(all_bcd(bus.count)), 16'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
